// File: rtl/carry_lookahead_adder.sv
// Purpose : unsigned WIDTH-bit adder built from a two-level carry-lookahead network with no ripple carry.
// Latency : o_result is combinational (0 cycles); o_result_q is the same sum registered one clk later.
// Backpres: none; a new operand pair is accepted every cycle, and rst_n only clears o_result_q.
module carry_lookahead_adder #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    output logic [WIDTH:0]   o_result,
    output logic [WIDTH:0]   o_result_q
);

    // Number of 4-bit groups. The last group is partial when WIDTH is not a multiple of 4.
    localparam int NGRP = (WIDTH + 3) / 4;

    // Number of group carries the second level must produce above carry-in.
    // When the top group is full, the carry-out of the adder is the second-level carry into
    // group NGRP. When the top group is partial, that group forms the carry-out internally,
    // so the second level only needs to feed groups 1 .. NGRP-1.
    localparam int NC = ((WIDTH % 4) == 0) ? NGRP : (NGRP - 1);

    // The adder has no carry input, so carry-in is tied low.
    localparam logic CIN = 1'b0;

    logic [WIDTH-1:0] g;       // bit generate
    logic [WIDTH-1:0] p;       // bit propagate
    logic [WIDTH:0]   c;       // carry into each bit; c[WIDTH] is the carry-out
    logic [NC:0]      grp_c;   // carry into each group, produced by the second level

    // Bit-level generate and propagate terms.
    assign g = i_add1 & i_add2;
    assign p = i_add1 ^ i_add2;

    // Second-level lookahead. Each group carry is a flat sum of products of the group
    // G/P terms and carry-in. No group carry is derived from a lower group carry.
    if (NC > 0) begin : g_lvl2
        logic [NC-1:0] grp_g;
        logic [NC-1:0] grp_p;

        // Group generate and propagate for every full group that feeds a higher carry.
        for (genvar gi = 0; gi < NC; gi++) begin : g_gp
            localparam int B = 4 * gi;
            assign grp_g[gi] = g[B+3]
                             | (p[B+3] & g[B+2])
                             | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign grp_p[gi] = p[B+3] & p[B+2] & p[B+1] & p[B];
        end

        // Flat lookahead expansion of every group carry-in from G, P and carry-in.
        always_comb begin
            logic acc;
            logic term;
            grp_c    = '0;
            grp_c[0] = CIN;
            for (int k = 1; k <= NC; k++) begin
                acc = 1'b0;
                // Products of the form G[j] & P[j+1] & ... & P[k-1].
                for (int j = 0; j < k; j++) begin
                    term = grp_g[j];
                    for (int m = j + 1; m < k; m++) begin
                        term = term & grp_p[m];
                    end
                    acc = acc | term;
                end
                // The carry-in product: P[0] & ... & P[k-1] & CIN.
                term = CIN;
                for (int m = 0; m < k; m++) begin
                    term = term & grp_p[m];
                end
                acc      = acc | term;
                grp_c[k] = acc;
            end
        end
    end else begin : g_no_lvl2
        // A single partial group needs no second level; its carry-in is the adder carry-in.
        assign grp_c = CIN;
    end

    // First-level lookahead inside each group. Every carry is written out as a flat
    // expansion of the bit terms and the group carry-in. Carries that fall beyond the
    // top bit are not built, so a partial top group stops at c[WIDTH].
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        localparam int B = 4 * gi;

        assign c[B] = grp_c[gi];

        if (B + 1 <= WIDTH) begin : g_c1
            assign c[B+1] = g[B]
                          | (p[B] & grp_c[gi]);
        end

        if (B + 2 <= WIDTH) begin : g_c2
            assign c[B+2] = g[B+1]
                          | (p[B+1] & g[B])
                          | (p[B+1] & p[B] & grp_c[gi]);
        end

        if (B + 3 <= WIDTH) begin : g_c3
            assign c[B+3] = g[B+2]
                          | (p[B+2] & g[B+1])
                          | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
        end
    end

    // When the top group is full, its carry-out comes straight from the second level.
    if ((WIDTH % 4) == 0) begin : g_cout_lvl2
        assign c[WIDTH] = grp_c[NC];
    end

    // Sum bits, with the carry-out of the top bit as the extra MSB.
    assign o_result = {c[WIDTH], p ^ c[WIDTH-1:0]};

    // Registered copy of the sum. An asynchronous reset clears it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_result_q <= '0;
        end else begin
            o_result_q <= o_result;
        end
    end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Bench for carry_lookahead_adder at WIDTH 3, 8 and 13.
// It uses directed vectors, an exhaustive 3-bit sweep, registered-path and async-reset sequences, and a random 13-bit regression.
// It checks every result against sums that the bench computes itself.
module tb_carry_lookahead_adder;

    logic clk;
    logic rst_n;

    logic [2:0]  a3,  b3;
    logic [3:0]  r3,  q3;
    logic [7:0]  a8,  b8;
    logic [8:0]  r8,  q8;
    logic [12:0] a13, b13;
    logic [13:0] r13, q13;

    int checks;
    int errors;

    carry_lookahead_adder #(.WIDTH(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_add1     (a3),
        .i_add2     (b3),
        .o_result   (r3),
        .o_result_q (q3)
    );

    carry_lookahead_adder #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_add1     (a8),
        .i_add2     (b8),
        .o_result   (r8),
        .o_result_q (q8)
    );

    carry_lookahead_adder #(.WIDTH(13)) u_dut13 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_add1     (a13),
        .i_add2     (b13),
        .o_result   (r13),
        .o_result_q (q13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          w;
        int unsigned a;
        int unsigned b;
        int unsigned exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        int unsigned prev;
        bit          have_prev;
        int unsigned ra, rb;

        checks = 0;
        errors = 0;
        a3 = '0; b3 = '0; a8 = '0; b8 = '0; a13 = '0; b13 = '0;
        rst_n = 1'b1;

        // Reset state: all registered sums are cleared while rst_n is low.
        #1 rst_n = 1'b0;
        #1;
        check("reset_q3",  32'(q3),  32'd0);
        check("reset_q8",  32'(q8),  32'd0);
        check("reset_q13", 32'(q13), 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold_q3", 32'(q3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed sums.
        vecs.push_back('{"w3_3p4",        3, 3,    4,    7});
        vecs.push_back('{"w3_5p6",        3, 5,    6,    11});
        vecs.push_back('{"w3_7p7",        3, 7,    7,    14});
        vecs.push_back('{"w3_0p0",        3, 0,    0,    0});
        vecs.push_back('{"w3_7p1",        3, 7,    1,    8});
        vecs.push_back('{"w8_255p1",      8, 255,  1,    256});
        vecs.push_back('{"w8_15p1",       8, 15,   1,    16});
        vecs.push_back('{"w8_128p128",    8, 128,  128,  256});
        vecs.push_back('{"w8_170p85",     8, 170,  85,   255});
        vecs.push_back('{"w8_240p16",     8, 240,  16,   256});
        vecs.push_back('{"w13_8191p1",   13, 8191, 1,    8192});
        vecs.push_back('{"w13_4095p1",   13, 4095, 1,    4096});
        vecs.push_back('{"w13_max_max",  13, 8191, 8191, 16382});
        vecs.push_back('{"w13_4096p4096",13, 4096, 4096, 8192});

        foreach (vecs[i]) begin
            @(negedge clk);
            case (vecs[i].w)
                3:       begin a3  = 3'(vecs[i].a);  b3  = 3'(vecs[i].b);  end
                8:       begin a8  = 8'(vecs[i].a);  b8  = 8'(vecs[i].b);  end
                default: begin a13 = 13'(vecs[i].a); b13 = 13'(vecs[i].b); end
            endcase
            #2;
            case (vecs[i].w)
                3:       check(vecs[i].name, 32'(r3),  vecs[i].exp);
                8:       check(vecs[i].name, 32'(r8),  vecs[i].exp);
                default: check(vecs[i].name, 32'(r13), vecs[i].exp);
            endcase
        end

        // Carry-out bit for 7+1 at WIDTH 3.
        @(negedge clk);
        a3 = 3'd7; b3 = 3'd1;
        #2;
        check("w3_cout_bit", 32'(r3[3]), 32'd1);

        // Exhaustive sweep at WIDTH 3, which also tracks the registered copy.
        have_prev = 1'b0;
        prev      = 0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                if (have_prev) check("w3_exh_q", 32'(q3), prev);
                a3 = 3'(a);
                b3 = 3'(b);
                #2;
                check("w3_exh", 32'(r3), 32'(a + b));
                prev      = 32'(a + b);
                have_prev = 1'b1;
            end
        end

        // Registered path: 2+3, then 6+1.
        @(negedge clk);
        a3 = 3'd2; b3 = 3'd3;
        @(negedge clk);
        check("w3_q_2p3", 32'(q3), 32'd5);
        a3 = 3'd6; b3 = 3'd1;
        @(negedge clk);
        check("w3_q_6p1", 32'(q3), 32'd7);

        // Asynchronous reset between clock edges while o_result_q holds 7.
        #2 rst_n = 1'b0;
        #1;
        check("w3_async_rst_q", 32'(q3), 32'd0);
        check("w3_async_rst_r", 32'(r3), 32'd7);
        @(posedge clk);
        #1;
        check("w3_rst_hold_q", 32'(q3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("w3_rel_before_edge", 32'(q3), 32'd0);
        @(posedge clk);
        #1;
        check("w3_rel_reload", 32'(q3), 32'd7);

        // Random regression at WIDTH 13, where the top group is partial.
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            ra  = $urandom_range(8191, 0);
            rb  = $urandom_range(8191, 0);
            a13 = 13'(ra);
            b13 = 13'(rb);
            #2;
            check("w13_rand", 32'(r13), ra + rb);
        end

        // Registered copy at WIDTH 8 and WIDTH 13.
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; a13 = 13'd5000; b13 = 13'd4000;
        @(negedge clk);
        check("w8_q_200p100",   32'(q8),  32'd300);
        check("w13_q_5000p4000", 32'(q13), 32'd9000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
